seq_divmod: RTL and testbench
=============================

# seq_divmod

Multi-cycle integer divider producing quotient and remainder from one radix-2 restoring datapath. It generalises the team's combinational MOD block in four ways: parametrised width, a per-operation signed/unsigned mode, valid/ready handshakes on input and output, and defined divide-by-zero behaviour. It sits between an operand producer and a result consumer, and trades DATAWIDTH+2 cycles of latency for a single subtractor.

## Interface
- DATAWIDTH, default 32: width of operands and results; legal range 2 and above.
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  DATAWIDTH  dividend.
- b  input  DATAWIDTH  divisor.
- is_signed  input  1  1 selects two's-complement operation; 0 selects unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- quot  output  DATAWIDTH  quotient.
- rem  output  DATAWIDTH  remainder.
- div_zero  output  1  result came from b == 0.

## Operation
- States:
  - IDLE: in_ready=1.
  - CALC: DATAWIDTH iterations.
  - FIX: sign correction.
  - DONE: out_valid=1.
- IDLE -> CALC on accept (in_valid & in_ready at an edge) with b != 0.
  - Latch is_signed, the sign of a, and the sign of b.
  - Latch |a| and |b| as magnitudes when signed; raw a and b when unsigned.
  - Clear the partial remainder.
  - Load the iteration counter with DATAWIDTH-1.
- IDLE -> DONE on accept with b == 0. Load:
  - quot = all ones;
  - rem = a;
  - div_zero = 1.
  - This holds in both modes.
- CALC, once per edge:
  - Shift {partial_rem, dividend} left by one.
  - Trial-subtract the divisor magnitude using a DATAWIDTH+1-bit subtractor.
  - If the difference is non-negative, keep it and shift in a quotient bit of 1; otherwise shift in 0.
  - Decrement the counter.
  - Go to FIX on the edge where the counter is 0.
- FIX, one edge:
  - In signed mode, negate quot if sign(a) != sign(b), and negate rem if sign(a) = 1.
  - Quotient truncates toward zero; the remainder takes the dividend's sign, matching Verilog signed / and %.
  - In unsigned mode, pass values through unchanged.
  - Go to DONE.
- DONE: hold quot, rem and div_zero stable while out_ready=0. On the edge with out_ready=1, go to IDLE and clear out_valid.
- in_ready=1 only in IDLE. There is no accept in the same cycle as a DONE->IDLE handoff, so at most one operation is in flight.
- Signed overflow: most-negative / -1 yields quot = most-negative and rem = 0. This falls out of the magnitude arithmetic and needs no special case.
- Inputs a, b and is_signed are ignored outside the accept edge.

## Timing
- Reset values:
  - state = IDLE;
  - in_ready = 1 (combinational from state);
  - out_valid = 0;
  - quot = 0;
  - rem = 0;
  - div_zero = 0.
- Normal latency:
  - Accept at edge T; out_valid rises after edge T+DATAWIDTH+1.
  - CALC occupies edges T+1..T+DATAWIDTH; FIX is edge T+DATAWIDTH+1.
  - For DATAWIDTH=32, out_valid is first sampled high at edge T+34.
- Divide-by-zero latency: out_valid is high after edge T and first sampled at edge T+1.
- Throughput: at most one operation per DATAWIDTH+3 cycles under no backpressure.
- rst has priority over every other event. If asserted in any state, including mid-CALC or in DONE with out_valid=1, it aborts the operation, and the next cycle shows reset values. No partial result is emitted.
- div_zero is cleared on each accept with b != 0.

## Test plan
- Unsigned, a=1, b=0x80000000 (DATAWIDTH=32) -> quot=0, rem=1, div_zero=0; out_valid first sampled high exactly 34 edges after accept.
- Unsigned, a=100, b=7 -> quot=14, rem=2. Then signed, a=-7 (0xFFFFFFF9), b=2 -> quot=0xFFFFFFFD (-3), rem=0xFFFFFFFF (-1).
- Divide by zero: a=5, b=0 in both modes -> quot=0xFFFFFFFF, rem=5, div_zero=1, out_valid one edge after accept. The next operation, 9/3, -> quot=3, div_zero=0.
- Signed overflow: a=0x80000000, b=0xFFFFFFFF -> quot=0x80000000, rem=0. Unsigned with the same operands -> quot=0, rem=0x80000000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises -> quot, rem and div_zero stay constant, in_ready=0, and in_valid pulses are not accepted. Releasing out_ready gives in_ready=1 on the next cycle.
- Reset mid-operation: assert rst 10 edges into CALC -> all outputs at reset values and in_ready=1 the next cycle. A subsequent 50/8 -> quot=6, rem=2. A randomized $urandom sweep in both modes is checked against a/b and a%b through error_monitor.

Source files
------------

// File: rtl/seq_divmod.sv
// Multi-cycle radix-2 restoring divider: quotient and remainder, signed or unsigned per operation.
// Valid/ready handshakes on both sides; divide-by-zero returns all-ones quotient and the dividend.
module seq_divmod #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] quot,
    output logic [DATAWIDTH-1:0] rem,
    output logic                 div_zero
);

    localparam int CW = (DATAWIDTH > 2) ? $clog2(DATAWIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [DATAWIDTH-1:0]   r_quot;      // dividend shifts out as quotient bits shift in
    logic [DATAWIDTH-1:0]   r_rem;       // partial remainder
    logic [DATAWIDTH-1:0]   r_divisor;
    logic [CW-1:0]          r_cnt;
    logic                   r_signed;
    logic                   r_sign_a;
    logic                   r_sign_b;
    logic                   r_div_zero;

    logic                   w_accept;
    logic                   w_b_zero;
    logic [DATAWIDTH-1:0]   w_a_mag;
    logic [DATAWIDTH-1:0]   w_b_mag;
    logic [DATAWIDTH:0]     w_shift;
    logic [DATAWIDTH:0]     w_diff;

    assign w_accept = in_valid & in_ready;
    assign w_b_zero = (b == '0);
    assign w_a_mag  = (is_signed && a[DATAWIDTH-1]) ? -a : a;
    assign w_b_mag  = (is_signed && b[DATAWIDTH-1]) ? -b : b;

    // The partial remainder is always below the divisor, so bit DATAWIDTH of the
    // difference is a reliable borrow flag for the trial subtraction.
    assign w_shift  = {r_rem, r_quot[DATAWIDTH-1]};
    assign w_diff   = w_shift - {1'b0, r_divisor};

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next_state = w_b_zero ? DONE : CALC;
            end
            CALC: if (r_cnt == '0) w_next_state = FIX;
            FIX:  w_next_state = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: only the registers visible on the outputs are reset; the divisor, counter and
    // sign flags are always loaded on accept before anything reads them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_quot     <= '0;
            r_rem      <= '0;
            r_div_zero <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: if (w_accept) begin
                    if (w_b_zero) begin
                        r_quot     <= '1;
                        r_rem      <= a;
                        r_div_zero <= 1'b1;
                    end else begin
                        r_quot     <= w_a_mag;
                        r_rem      <= '0;
                        r_div_zero <= 1'b0;
                    end
                end
                CALC: begin
                    r_rem  <= w_diff[DATAWIDTH] ? w_shift[DATAWIDTH-1:0] : w_diff[DATAWIDTH-1:0];
                    r_quot <= {r_quot[DATAWIDTH-2:0], ~w_diff[DATAWIDTH]};
                end
                FIX: if (r_signed) begin
                    if (r_sign_a ^ r_sign_b) r_quot <= -r_quot;
                    if (r_sign_a)            r_rem  <= -r_rem;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == IDLE && w_accept) begin
            r_divisor <= w_b_mag;
            r_cnt     <= CW'(DATAWIDTH - 1);
            r_signed  <= is_signed;
            r_sign_a  <= a[DATAWIDTH-1];
            r_sign_b  <= b[DATAWIDTH-1];
        end else if (r_state == CALC) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign quot     = r_quot;
    assign rem      = r_rem;
    assign div_zero = r_div_zero;

endmodule

// File: tb/tb_seq_divmod.sv
// Self-checking bench for seq_divmod: directed corner cases, backpressure, mid-operation reset,
// and a randomized sweep against an arithmetic reference model.
module tb_seq_divmod;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         is_signed;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         div_zero;

    int checks   = 0;
    int failures = 0;

    seq_divmod #(.DATAWIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division, signed done in 64-bit to cover most-negative / -1.
    function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        longint sa, sb;
        if (bv == '0) begin
            q = '1;
            r = av;
            z = 1'b1;
        end else if (!sv) begin
            q = av / bv;
            r = av % bv;
            z = 1'b0;
        end else begin
            sa = longint'($signed(av));
            sb = longint'($signed(bv));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
            z  = 1'b0;
        end
    endfunction

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv,
                          input int hold, input string tag);
        logic [W-1:0] eq, er;
        logic         ez;
        int           lat;
        model(av, bv, sv, eq, er, ez);
        @(negedge clk);
        check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        is_signed = sv;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        a         = $urandom;
        b         = $urandom;
        is_signed = 1'($urandom);
        check({tag, ".in_ready_busy"}, 64'(in_ready), 64'd0);
        lat = 1;
        while (lat < 100) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), ez ? 64'd1 : 64'(W + 2));
        check({tag, ".quot"}, 64'(quot), 64'(eq));
        check({tag, ".rem"}, 64'(rem), 64'(er));
        check({tag, ".div_zero"}, 64'(div_zero), 64'(ez));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1;
                a        = $urandom;
                b        = $urandom;
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                check({tag, ".bp_valid"}, 64'(out_valid), 64'd1);
                check({tag, ".bp_in_ready"}, 64'(in_ready), 64'd0);
                check({tag, ".bp_quot"}, 64'(quot), 64'(eq));
                check({tag, ".bp_rem"}, 64'(rem), 64'(er));
                check({tag, ".bp_div_zero"}, 64'(div_zero), 64'(ez));
                @(negedge clk);
            end
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        check({tag, ".handoff_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".handoff_ready"}, 64'(in_ready), 64'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".quot"}, 64'(quot), 64'd0);
        check({tag, ".rem"}, 64'(rem), 64'd0);
        check({tag, ".div_zero"}, 64'(div_zero), 64'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        is_signed = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        run_op(32'd1, 32'h8000_0000, 1'b0, 0, "u_1_by_msb");
        run_op(32'd100, 32'd7, 1'b0, 0, "u_100_7");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0, "s_m7_2");
        run_op(32'd5, 32'd0, 1'b0, 0, "u_div0");
        run_op(32'd5, 32'd0, 1'b1, 0, "s_div0");
        run_op(32'd9, 32'd3, 1'b0, 0, "u_9_3");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, "s_ovf");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "u_ovf_ops");
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 5, "s_bp");
        run_op(32'd3, 32'd0, 1'b0, 3, "div0_bp");

        // Reset partway through CALC aborts the operation.
        @(negedge clk);
        in_valid = 1'b1;
        a        = 32'd1000;
        b        = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_reset.no_result", 64'(out_valid), 64'd0);
        run_op(32'd50, 32'd8, 1'b0, 0, "after_reset");

        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'($urandom_range(1, 15));
                1:       rb = 32'($urandom_range(0, 1)) ? 32'hFFFF_FFFF : 32'h8000_0000;
                2:       rb = (i % 10 == 0) ? 32'd0 : 32'($urandom_range(1, 255));
                default: rb = $urandom;
            endcase
            run_op(ra, rb, 1'($urandom), 0, $sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
